// File: rtl/join_pkg.sv
// Shared definitions for the N-way handshake join.
//   join_state_e : join controller states
//   PHASE_4 / PHASE_2 : values of the PHASE4 parameter selecting the
//                       return-to-zero or the transition protocol
package join_pkg;

    typedef enum logic [1:0] {
        COLLECT    = 2'd0,
        WAIT_ACK   = 2'd1,
        WAIT_RTZ   = 2'd2,
        WAIT_ACKLO = 2'd3
    } join_state_e;

    localparam int PHASE_4 = 1;
    localparam int PHASE_2 = 0;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for asynchronous handshake inputs.
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous reset, active-high, clears every stage
//   d_i    : asynchronous input vector (WIDTH bits)
//   q_o    : synchronised output, STAGES clocks behind d_i
// With STAGES = 0 the input is passed straight through.
module sync_ff #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk_i | rst_i;
            assign q_o = d_i;
        end else begin : g_sync
            logic [WIDTH-1:0] stage_q [STAGES];
            logic [WIDTH-1:0] stage_d [STAGES];

            always_comb begin
                stage_d[0] = d_i;
                for (int s = 1; s < STAGES; s++) begin
                    stage_d[s] = stage_q[s-1];
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int s = 0; s < STAGES; s++) begin
                        stage_q[s] <= '0;
                    end
                end else begin
                    for (int s = 0; s < STAGES; s++) begin
                        stage_q[s] <= stage_d[s];
                    end
                end
            end

            assign q_o = stage_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/join_n_sync.sv
// Clocked N-way handshake join for a bundled-data pipeline.
// Collects a request from every enabled input channel, then issues a single
// downstream request carrying all captured channel data, and returns the
// acknowledge to the contributing channels once downstream acknowledges.
// Ports:
//   clk_i      : clock
//   rst_i      : asynchronous reset, active-high
//   req_in_i   : per-channel request (asynchronous, synchronised here)
//   data_in_i  : per-channel bundled data, channel i at [i*DATA_W +: DATA_W]
//   chan_en_i  : channel participation mask, frozen when the join fires
//   ack_out_i  : downstream acknowledge (asynchronous, synchronised here)
//   ack_in_o   : per-channel acknowledge
//   req_out_o  : downstream request
//   data_out_o : captured data, same packing as data_in_i
//   busy_o     : high whenever a join is in flight
//   txn_cnt_o  : completed handshakes, wraps silently
module join_n_sync
    import join_pkg::*;
#(
    parameter int N_IN        = 3,
    parameter int DATA_W      = 8,
    parameter int PHASE4      = 1,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_IN-1:0]        req_in_i,
    input  logic [N_IN*DATA_W-1:0] data_in_i,
    input  logic [N_IN-1:0]        chan_en_i,
    input  logic                   ack_out_i,
    output logic [N_IN-1:0]        ack_in_o,
    output logic                   req_out_o,
    output logic [N_IN*DATA_W-1:0] data_out_o,
    output logic                   busy_o,
    output logic [CNT_W-1:0]       txn_cnt_o
);

    localparam bit IS_4P = (PHASE4 == PHASE_4);

    logic [N_IN-1:0] req_s;
    logic            ack_s;

    sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(N_IN)) u_req_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (req_in_i),
        .q_o   (req_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_ack_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (ack_out_i),
        .q_o   (ack_s)
    );

    join_state_e             state_q, state_d;
    logic [N_IN-1:0]         arrived_q, arrived_d;
    logic [N_IN-1:0]         mask_q, mask_d;
    logic [N_IN-1:0]         in_phase_q, in_phase_d;
    logic [N_IN-1:0]         ack_in_q, ack_in_d;
    logic [N_IN-1:0]         req_r_q, req_r_d;
    logic                    ack_r_q, ack_r_d;
    logic                    ack_phase_q, ack_phase_d;
    logic                    req_out_q, req_out_d;
    logic [N_IN*DATA_W-1:0]  data_q, data_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [N_IN-1:0]         arrive_now;
    logic                    fire;

    always_comb begin
        state_d     = state_q;
        arrived_d   = arrived_q;
        mask_d      = mask_q;
        in_phase_d  = in_phase_q;
        ack_in_d    = ack_in_q;
        ack_phase_d = ack_phase_q;
        req_out_d   = req_out_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        // The FSM decides on a registered copy of the synchronised handshake
        // inputs, which gives request and acknowledge paths the same latency.
        req_r_d     = req_s;
        ack_r_d     = ack_s;

        // Only enabled channels can arrive; disabled ones are treated as
        // already present by the fire condition instead.
        if (IS_4P) begin
            arrive_now = req_s & chan_en_i;
        end else begin
            arrive_now = (req_s ^ in_phase_q) & chan_en_i;
        end
        fire = (&(arrived_q | ~chan_en_i)) && (|chan_en_i);

        case (state_q)
            COLLECT: begin
                arrived_d = arrived_q | arrive_now;
                for (int i = 0; i < N_IN; i++) begin
                    if (arrive_now[i] && !arrived_q[i]) begin
                        data_d[i*DATA_W +: DATA_W] = data_in_i[i*DATA_W +: DATA_W];
                    end
                end
                // The mask tracks chan_en_i until the join fires, then holds.
                mask_d = chan_en_i;
                if (fire) begin
                    req_out_d = IS_4P ? 1'b1 : ~req_out_q;
                    state_d   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (IS_4P) begin
                    if (ack_r_q) begin
                        ack_in_d = mask_q;
                        state_d  = WAIT_RTZ;
                    end
                end else if (ack_r_q != ack_phase_q) begin
                    ack_in_d    = ack_in_q ^ mask_q;
                    in_phase_d  = in_phase_q ^ mask_q;
                    ack_phase_d = ~ack_phase_q;
                    arrived_d   = '0;
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = COLLECT;
                end
            end
            WAIT_RTZ: begin
                if ((req_r_q & mask_q) == '0) begin
                    req_out_d = 1'b0;
                    state_d   = WAIT_ACKLO;
                end
            end
            WAIT_ACKLO: begin
                if (!ack_r_q) begin
                    ack_in_d  = '0;
                    arrived_d = '0;
                    cnt_d     = cnt_q + CNT_W'(1);
                    state_d   = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= COLLECT;
            arrived_q   <= '0;
            mask_q      <= '0;
            in_phase_q  <= '0;
            ack_in_q    <= '0;
            req_r_q     <= '0;
            ack_r_q     <= 1'b0;
            ack_phase_q <= 1'b0;
            req_out_q   <= 1'b0;
            data_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            arrived_q   <= arrived_d;
            mask_q      <= mask_d;
            in_phase_q  <= in_phase_d;
            ack_in_q    <= ack_in_d;
            req_r_q     <= req_r_d;
            ack_r_q     <= ack_r_d;
            ack_phase_q <= ack_phase_d;
            req_out_q   <= req_out_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ack_in_o   = ack_in_q;
    assign req_out_o  = req_out_q;
    assign data_out_o = data_q;
    assign busy_o     = (state_q != COLLECT);
    assign txn_cnt_o  = cnt_q;

endmodule

// File: tb/tb_join_n_sync.sv
// Bench for join_n_sync: a 4-phase instance (2 sync stages, 4-bit counter)
// and a 2-phase instance (no sync stages, 16-bit counter). A zero-latency
// protocol model follows every input change; once the inputs have been quiet
// long enough for the DUT to settle, all outputs are compared with it each
// cycle. Directed literal checks pin the model and the exact latencies.
module tb_join_n_sync;

    localparam int N  = 3;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [N-1:0]    req4, en4, req2, en2;
    logic [N*DW-1:0] data4, data2;
    logic            ack4, ack2;

    logic [N-1:0]    u4_ack_in, u2_ack_in;
    logic            u4_req_out, u2_req_out, u4_busy, u2_busy;
    logic [N*DW-1:0] u4_data, u2_data;
    logic [3:0]      u4_cnt;
    logic [15:0]     u2_cnt;

    join_n_sync #(.N_IN(N), .DATA_W(DW), .PHASE4(1), .SYNC_STAGES(2), .CNT_W(4)) u4 (
        .clk_i(clk), .rst_i(rst), .req_in_i(req4), .data_in_i(data4),
        .chan_en_i(en4), .ack_out_i(ack4), .ack_in_o(u4_ack_in),
        .req_out_o(u4_req_out), .data_out_o(u4_data), .busy_o(u4_busy),
        .txn_cnt_o(u4_cnt)
    );

    join_n_sync #(.N_IN(N), .DATA_W(DW), .PHASE4(0), .SYNC_STAGES(0), .CNT_W(16)) u2 (
        .clk_i(clk), .rst_i(rst), .req_in_i(req2), .data_in_i(data2),
        .chan_en_i(en2), .ack_out_i(ack2), .ack_in_o(u2_ack_in),
        .req_out_o(u2_req_out), .data_out_o(u2_data), .busy_o(u2_busy),
        .txn_cnt_o(u2_cnt)
    );

    // ---------------- protocol model (index 0: 4-phase, 1: 2-phase) -------
    int              m_st   [2];   // 0 idle/collecting, 1 req sent, 2 acked, 3 req withdrawn
    logic [N-1:0]    m_arr  [2];
    logic [N-1:0]    m_mask [2];
    logic [N-1:0]    m_inph [2];
    logic [N-1:0]    m_ack  [2];
    logic            m_req  [2];
    logic            m_ackph[2];
    logic [N*DW-1:0] m_data [2];
    int              m_cnt  [2];
    int              stamp = 0;
    int              n_chk = 0;
    int              n_err = 0;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_st[d] = 0; m_arr[d] = '0; m_mask[d] = '0; m_inph[d] = '0;
            m_ack[d] = '0; m_req[d] = 1'b0; m_ackph[d] = 1'b0;
            m_data[d] = '0; m_cnt[d] = 0;
        end
    endtask

    // Apply the join rules repeatedly until nothing changes.
    task automatic model_eval(input int d, input bit p4, input logic [N-1:0] r,
                              input logic [N*DW-1:0] din, input logic [N-1:0] e,
                              input logic a);
        for (int it = 0; it < 8; it++) begin
            case (m_st[d])
                0: begin
                    for (int i = 0; i < N; i++) begin
                        if (e[i] && !m_arr[d][i] && (p4 ? r[i] : (r[i] != m_inph[d][i]))) begin
                            m_arr[d][i] = 1'b1;
                            m_data[d][i*DW +: DW] = din[i*DW +: DW];
                        end
                    end
                    if (((m_arr[d] | ~e) == '1) && (e != '0)) begin
                        m_req[d]  = p4 ? 1'b1 : ~m_req[d];
                        m_mask[d] = e;
                        m_st[d]   = 1;
                    end
                end
                1: begin
                    if (p4 && a) begin
                        m_ack[d] = m_mask[d];
                        m_st[d]  = 2;
                    end else if (!p4 && (a != m_ackph[d])) begin
                        m_ack[d]   = m_ack[d] ^ m_mask[d];
                        m_inph[d]  = m_inph[d] ^ m_mask[d];
                        m_ackph[d] = ~m_ackph[d];
                        m_arr[d]   = '0;
                        m_cnt[d]   = m_cnt[d] + 1;
                        m_st[d]    = 0;
                    end
                end
                2: begin
                    if ((r & m_mask[d]) == '0) begin
                        m_req[d] = 1'b0;
                        m_st[d]  = 3;
                    end
                end
                default: begin
                    if (!a) begin
                        m_ack[d] = '0;
                        m_arr[d] = '0;
                        m_cnt[d] = m_cnt[d] + 1;
                        m_st[d]  = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        if (!rst && (cyc - stamp) >= 9) begin
            chk("u4_req_out", 64'(u4_req_out), 64'(m_req[0]));
            chk("u4_ack_in",  64'(u4_ack_in),  64'(m_ack[0]));
            chk("u4_data",    64'(u4_data),    64'(m_data[0]));
            chk("u4_busy",    64'(u4_busy),    64'(m_st[0] != 0));
            chk("u4_cnt",     64'(u4_cnt),     64'(m_cnt[0] % 16));
            chk("u2_req_out", 64'(u2_req_out), 64'(m_req[1]));
            chk("u2_ack_in",  64'(u2_ack_in),  64'(m_ack[1]));
            chk("u2_data",    64'(u2_data),    64'(m_data[1]));
            chk("u2_busy",    64'(u2_busy),    64'(m_st[1] != 0));
            chk("u2_cnt",     64'(u2_cnt),     64'(m_cnt[1] % 65536));
        end
    endtask

    task automatic drive4(input logic [N-1:0] r, input logic [N*DW-1:0] dd,
                          input logic [N-1:0] e, input logic a);
        @(posedge clk); #1;
        req4 = r; data4 = dd; en4 = e; ack4 = a;
        model_eval(0, 1'b1, r, dd, e, a);
        stamp = cyc;
    endtask

    task automatic drive2(input logic [N-1:0] r, input logic [N*DW-1:0] dd, input logic a);
        @(posedge clk); #1;
        req2 = r; data2 = dd; ack2 = a;
        model_eval(1, 1'b0, r, dd, en2, a);
        stamp = cyc;
    endtask

    task automatic settle();
        repeat (12) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic txn4(input logic [N*DW-1:0] dd);
        drive4(3'b111, dd, 3'b111, 1'b0); settle();
        drive4(3'b111, dd, 3'b111, 1'b1); settle();
        drive4(3'b000, dd, 3'b111, 1'b1); settle();
        drive4(3'b000, dd, 3'b111, 1'b0); settle();
    endtask

    initial begin
        rst = 1'b1;
        req4 = '0; data4 = '0; en4 = 3'b111; ack4 = 1'b0;
        req2 = '0; data2 = '0; en2 = 3'b111; ack2 = 1'b0;
        model_reset();

        fork
            forever begin
                @(negedge clk);
                compare();
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_out", 64'(u4_req_out), 64'd0);
        chk("rst_ack_in",  64'(u4_ack_in),  64'd0);
        chk("rst_data",    64'(u4_data),    64'd0);
        chk("rst_busy",    64'(u4_busy),    64'd0);
        chk("rst_cnt",     64'(u4_cnt),     64'd0);
        rst = 1'b0;
        stamp = cyc;
        repeat (4) @(posedge clk);

        // 4-phase, all channels: requests on cycles 0, 5, 9 -> fire on edge 13
        drive4(3'b001, 24'h000011, 3'b111, 1'b0);
        repeat (4) @(posedge clk);
        drive4(3'b011, 24'h002211, 3'b111, 1'b0);
        repeat (3) @(posedge clk);
        drive4(3'b111, 24'h332211, 3'b111, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("req_out_edge12", 64'(u4_req_out), 64'd0);
        @(negedge clk);
        chk("req_out_edge13", 64'(u4_req_out), 64'd1);
        settle();
        chk("data_332211", 64'(u4_data), 64'h332211);
        chk("busy_wait_ack", 64'(u4_busy), 64'd1);
        drive4(3'b111, 24'h332211, 3'b111, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ack_in_edge3", 64'(u4_ack_in), 64'd0);
        @(negedge clk);
        chk("ack_in_edge4", 64'(u4_ack_in), 64'b111);
        settle();
        drive4(3'b000, 24'h332211, 3'b111, 1'b1); settle();
        chk("req_out_rtz", 64'(u4_req_out), 64'd0);
        chk("ack_in_held", 64'(u4_ack_in), 64'b111);
        drive4(3'b000, 24'h332211, 3'b111, 1'b0); settle();
        chk("ack_in_low", 64'(u4_ack_in), 64'd0);
        chk("cnt_one",    64'(u4_cnt),    64'd1);
        chk("idle_busy",  64'(u4_busy),   64'd0);

        // Mask 101: channel 1 neither captured nor acknowledged
        drive4(3'b101, 24'hC255A0, 3'b101, 1'b0); settle();
        chk("m101_req_out", 64'(u4_req_out), 64'd1);
        chk("m101_data",    64'(u4_data),    64'hC222A0);
        drive4(3'b101, 24'hC255A0, 3'b010, 1'b0); settle();
        drive4(3'b101, 24'hC255A0, 3'b010, 1'b1); settle();
        chk("m101_ack_in", 64'(u4_ack_in), 64'b101);
        drive4(3'b000, 24'hC255A0, 3'b010, 1'b1); settle();
        chk("m101_rtz", 64'(u4_req_out), 64'd0);
        drive4(3'b000, 24'hC255A0, 3'b010, 1'b0); settle();
        chk("m101_cnt", 64'(u4_cnt), 64'd2);

        // Mask 000 never fires
        drive4(3'b111, 24'h010203, 3'b000, 1'b0);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            chk("m000_req_out", 64'(u4_req_out), 64'd0);
            chk("m000_busy",    64'(u4_busy),    64'd0);
        end
        drive4(3'b000, 24'h010203, 3'b000, 1'b0); settle();
        drive4(3'b000, 24'h010203, 3'b111, 1'b0); settle();

        // 2-phase, no synchronisers
        drive2(3'b111, 24'h665544, 1'b0); settle();
        chk("p2_req_out_1", 64'(u2_req_out), 64'd1);
        chk("p2_data_1",    64'(u2_data),    64'h665544);
        drive2(3'b111, 24'h665544, 1'b1); settle();
        chk("p2_ack_in_1", 64'(u2_ack_in), 64'b111);
        chk("p2_cnt_1",    64'(u2_cnt),    64'd1);
        drive2(3'b000, 24'h998877, 1'b1); settle();
        chk("p2_req_out_0", 64'(u2_req_out), 64'd0);
        chk("p2_data_2",    64'(u2_data),    64'h998877);
        drive2(3'b000, 24'h998877, 1'b0); settle();
        chk("p2_ack_in_0", 64'(u2_ack_in), 64'b000);
        chk("p2_cnt_2",    64'(u2_cnt),    64'd2);

        // Asynchronous reset while waiting for the acknowledge
        drive4(3'b111, 24'h0F0E0D, 3'b111, 1'b0); settle();
        chk("pre_rst_busy", 64'(u4_busy), 64'd1);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("arst_req_out", 64'(u4_req_out), 64'd0);
        chk("arst_ack_in",  64'(u4_ack_in),  64'd0);
        chk("arst_data",    64'(u4_data),    64'd0);
        chk("arst_busy",    64'(u4_busy),    64'd0);
        chk("arst_cnt",     64'(u4_cnt),     64'd0);
        chk("arst_u2_cnt",  64'(u2_cnt),     64'd0);
        req4 = '0; data4 = '0; en4 = 3'b111; ack4 = 1'b0;
        req2 = '0; data2 = '0; ack2 = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stamp = cyc;
        txn4(24'h313233);
        chk("post_rst_cnt",  64'(u4_cnt),  64'd1);
        chk("post_rst_data", 64'(u4_data), 64'h313233);

        // Counter wrap: 17 transactions in total on a 4-bit counter
        for (int t = 0; t < 16; t++) begin
            txn4(24'(t * 24'h010101));
        end
        chk("wrap_cnt", 64'(u4_cnt), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/join_n_sync.md
Name: join_n_sync

Overview:
- Clocked, parametrised N-way handshake join for the bundled-data pipeline.
- Waits until every enabled input channel has issued a request, then issues one output request carrying all captured input data.
- Returns acknowledges to the contributing channels once the downstream acknowledge arrives.
- Supports 4-phase (return-to-zero) or 2-phase (transition) signalling, a run-time channel mask, input synchronisers and a completed-transaction counter.

Parameters:
N_IN, 3, number of input channels (2..16)
DATA_W, 8, data width per channel
PHASE4, 1, 1 = 4-phase RTZ protocol, 0 = 2-phase transition protocol
SYNC_STAGES, 2, synchroniser flops on req_in_i and ack_out_i (0 = bypass)
CNT_W, 16, width of the transaction counter

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
req_in_i  in  N_IN  per-channel request
data_in_i  in  N_IN*DATA_W  per-channel bundled data, channel i at bits [i*DATA_W +: DATA_W]
chan_en_i  in  N_IN  channel participation mask
ack_out_i  in  1  downstream acknowledge
ack_in_o  out  N_IN  per-channel acknowledge
req_out_o  out  1  downstream request
data_out_o  out  N_IN*DATA_W  captured data, same packing as data_in_i
busy_o  out  1  high in any state other than COLLECT
txn_cnt_o  out  CNT_W  completed handshakes, wraps modulo 2^CNT_W

Behaviour:
- Reset: all outputs 0, arrived 0, mask 0, phase registers 0, state COLLECT. Reset mid-transaction aborts it without a completing edge; all synchroniser flops are cleared.
- Synchronisation: req_in_i and ack_out_i pass through SYNC_STAGES flops; the FSM sees only the synchronised versions (req_s, ack_s).
- Bundled data: data_in_i is stable while its request is pending and is sampled unsynchronised.
- Arrival, 4-phase: channel i has arrived when req_s[i] = 1.
- Arrival, 2-phase: channel i has arrived when req_s[i] != in_phase[i].
- Capture: arrived[i] is sticky and registered. On its 0->1 edge, data_in_i slice i is captured into data_out_o slice i.
- Mask:
  - chan_en_i is sampled every cycle in COLLECT and frozen into the mask register on exit from COLLECT.
  - Disabled channels count as arrived, get no capture, and never receive an ack edge; their data_out_o slice holds its old value.
  - An all-zero mask never fires; the FSM stays in COLLECT.
- FSM, 4-phase:
  - COLLECT: when (arrived | ~chan_en_i) is all ones and chan_en_i != 0, set req_out_o <= 1 -> WAIT_ACK.
  - WAIT_ACK: on ack_s = 1, set ack_in_o <= mask -> WAIT_RTZ.
  - WAIT_RTZ: when req_s & mask == 0, set req_out_o <= 0 -> WAIT_ACKLO.
  - WAIT_ACKLO: on ack_s = 0, set ack_in_o <= 0, clear arrived, increment txn_cnt -> COLLECT.
- FSM, 2-phase:
  - COLLECT: same fire condition; toggle req_out_o -> WAIT_ACK.
  - WAIT_ACK: on ack_s != ack_phase, toggle ack_in_o bits selected by mask, toggle in_phase bits selected by mask, toggle ack_phase, clear arrived, increment txn_cnt -> COLLECT.
- Latency (S = SYNC_STAGES): req_out_o changes at clock edge S+2 after the last enabled request change is first sampled (edge 1 = first sampling edge). Ack path latency is also S+2 edges.
- Simultaneous events: if all enabled requests arrive on the same edge, they are captured together and fire as normal. A request change on a channel that has already arrived is ignored until the next transaction.
- Counter: wraps from 2^CNT_W-1 to 0 with no flag.

Decomposition:
- Shared package join_pkg holds the FSM state enum (COLLECT, WAIT_ACK, WAIT_RTZ, WAIT_ACKLO) and the phase-mode constants.
- One natural sub-module: sync_ff, a parametrised SYNC_STAGES-deep synchroniser with asynchronous active-high reset. It is instantiated for the req_in_i vector and for ack_out_i.

Test Plan:
- 4-phase, N_IN=3, S=2, mask=111: raise req 0,1,2 on cycles 0, 5, 9 with data 0x11, 0x22, 0x33 -> req_out_o rises at edge 13, data_out_o=0x332211; ack high -> ack_in_o=111; reqs low -> req_out_o low; ack low -> ack_in_o=000, txn_cnt_o=1.
- Mask 101: only req 0 and req 2 raised -> fires; ack_in_o=101 and slice 1 unchanged; changing chan_en_i during WAIT_ACK has no effect.
- Mask 000 with all reqs high -> req_out_o stays 0 and busy_o stays 0 for 50 cycles.
- 2-phase, S=0: toggle all three reqs -> req_out_o toggles 0->1; toggle ack -> ack_in_o=111; toggle reqs again -> req_out_o 1->0; txn_cnt_o=2.
- Assert rst_i in WAIT_ACK -> all outputs 0 immediately (asynchronous, before the next edge); a fresh handshake then completes normally.
- CNT_W=4: run 17 transactions -> txn_cnt_o=1.
